// File: rtl/iqueue_ctrl_pkg.sv
// Shared sizing defaults for the vp sequencer instruction queue.
package iqueue_ctrl_pkg;

  localparam int unsigned CoeWidth        = 32;
  localparam int unsigned IqueueDepth     = 16;
  localparam int unsigned CommonBramDelay = 2;

  // Consumers size their credit counters from this value.
  localparam int unsigned IqueueObufDepth = CommonBramDelay + 1;

endpackage

// File: rtl/iqueue_ctrl_two_port_ram.sv
// Simple dual-port RAM: synchronous write on port A and a RD_DELAY-cycle
// read pipeline on port B. Contents are not reset.
module iqueue_ctrl_two_port_ram #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned RD_DELAY = 2,
  localparam int unsigned AWIDTH  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wea,
  input  logic [AWIDTH-1:0] i_addra,
  input  logic [DWIDTH-1:0] i_dina,
  input  logic              i_enb,
  input  logic [AWIDTH-1:0] i_addrb,
  output logic [DWIDTH-1:0] o_doutb
);

  logic [DWIDTH-1:0] r_mem  [DEPTH];
  logic [DWIDTH-1:0] r_pipe [RD_DELAY];

  always_ff @(posedge i_clk) begin
    if (i_wea) begin
      r_mem[i_addra] <= i_dina;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_enb) begin
      r_pipe[0] <= r_mem[i_addrb];
    end
    for (int i = 1; i < int'(RD_DELAY); i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_doutb = r_pipe[RD_DELAY-1];

endmodule

// File: rtl/iqueue_ctrl.sv
// Valid/ready FIFO controller around the instruction-queue RAM, with an output
// buffer hiding RAM read latency. `IQUEUE_FLUSH_EN adds the i_flush port.
module iqueue_ctrl
  import iqueue_ctrl_pkg::*;
#(
  parameter int unsigned DWIDTH     = CoeWidth,
  parameter int unsigned DEPTH      = IqueueDepth,
  parameter int unsigned RD_DELAY   = CommonBramDelay,
  localparam int unsigned AWIDTH     = $clog2(DEPTH),
  localparam int unsigned OBUF_DEPTH = RD_DELAY + 1,
  localparam int unsigned CWIDTH     = $clog2(DEPTH + OBUF_DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DWIDTH-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DWIDTH-1:0] o_out_data,
`ifdef IQUEUE_FLUSH_EN
  input  logic              i_flush,
`endif
  output logic [CWIDTH-1:0] o_count
);

  localparam int unsigned PW  = AWIDTH + 1;
  localparam int unsigned OPW = $clog2(OBUF_DEPTH);
  localparam int unsigned OCW = $clog2(OBUF_DEPTH + 1);
  localparam int unsigned OW  = OCW + 1;

  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [RD_DELAY-1:0] r_vld_sr;
  logic [DWIDTH-1:0]   r_obuf [OBUF_DEPTH];
  logic [OPW-1:0]      r_obuf_rd;
  logic [OPW-1:0]      r_obuf_wr;
  logic [OCW-1:0]      r_obuf_cnt;
  logic [CWIDTH-1:0]   r_count;

  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_capture;
  logic [PW-1:0]     w_ram_cnt;
  logic [OW-1:0]     w_inflight;
  logic [OW-1:0]     w_obuf_need;
  logic [DWIDTH-1:0] w_doutb;

`ifdef IQUEUE_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  // Registered write pointer only: a word written this cycle is read no earlier than next cycle.
  assign w_ram_cnt  = r_wr_ptr - r_rd_ptr;
  assign o_in_ready = (w_ram_cnt != PW'(DEPTH)) & ~i_rst & ~w_flush;
  assign w_push     = i_in_valid & o_in_ready;
  assign o_out_valid = (r_obuf_cnt != '0);
  assign w_pop      = o_out_valid & i_out_ready;
  assign w_capture  = r_vld_sr[RD_DELAY-1];
  assign o_out_data = r_obuf[r_obuf_rd];
  assign o_count    = r_count;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(RD_DELAY); i++) begin
      w_inflight = w_inflight + OW'(r_vld_sr[i]);
    end
  end

  // Reserve an obuf slot for every outstanding read so captures never overflow.
  assign w_obuf_need = w_inflight + OW'(r_obuf_cnt) - OW'(w_pop);
  assign w_issue     = (w_ram_cnt != '0) && (w_obuf_need < OW'(OBUF_DEPTH));

  function automatic logic [OPW-1:0] obuf_inc(input logic [OPW-1:0] p);
    return (p == OPW'(OBUF_DEPTH - 1)) ? '0 : p + OPW'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst || w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_vld_sr   <= '0;
      r_obuf_rd  <= '0;
      r_obuf_wr  <= '0;
      r_obuf_cnt <= '0;
      r_count    <= '0;
      for (int i = 0; i < int'(OBUF_DEPTH); i++) begin
        r_obuf[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_vld_sr <= (r_vld_sr << 1) | RD_DELAY'(w_issue);
      if (w_capture) begin
        r_obuf[r_obuf_wr] <= w_doutb;
        r_obuf_wr         <= obuf_inc(r_obuf_wr);
      end
      if (w_pop) begin
        r_obuf_rd <= obuf_inc(r_obuf_rd);
      end
      case ({w_capture, w_pop})
        2'b10:   r_obuf_cnt <= r_obuf_cnt + OCW'(1);
        2'b01:   r_obuf_cnt <= r_obuf_cnt - OCW'(1);
        default: r_obuf_cnt <= r_obuf_cnt;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CWIDTH'(1);
        2'b01:   r_count <= r_count - CWIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  iqueue_ctrl_two_port_ram #(
    .DWIDTH   (DWIDTH),
    .DEPTH    (DEPTH),
    .RD_DELAY (RD_DELAY)
  ) u_ram (
    .i_clk   (i_clk),
    .i_wea   (w_push),
    .i_addra (r_wr_ptr[AWIDTH-1:0]),
    .i_dina  (i_in_data),
    .i_enb   (w_issue),
    .i_addrb (r_rd_ptr[AWIDTH-1:0]),
    .o_doutb (w_doutb)
  );

  a_obuf_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_capture && !w_pop && (r_obuf_cnt == OCW'(OBUF_DEPTH))));

endmodule

// File: tb/tb_iqueue_ctrl.sv
// Scoreboard bench for iqueue_ctrl: a queue model fed on accepted pushes and
// checked on every pop, plus directed latency, fill, stream and reset scenarios.
module tb_iqueue_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int RD    = 2;
  localparam int CAP   = DEPTH + RD + 1;
  localparam int CW    = $clog2(CAP + 1);
  localparam int LAT   = RD + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          flush = 1'b0;

  int            checks = 0;
  int            failures = 0;
  int            n_acc = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] model_q[$];

  always #5 clk = ~clk;

  iqueue_ctrl #(
    .DWIDTH   (DW),
    .DEPTH    (DEPTH),
    .RD_DELAY (RD)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
`ifdef IQUEUE_FLUSH_EN
    .i_flush     (flush),
`endif
    .o_count     (count)
  );

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every cycle against the queue model.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [DW-1:0] exp_w;
      check(int'(count) == model_q.size(), "count", longint'(count), model_q.size());
      if (rst || flush) begin
        check(in_ready == 1'b0, "in_ready_blocked", in_ready, 0);
      end else if (model_q.size() < DEPTH) begin
        check(in_ready == 1'b1, "in_ready_space", in_ready, 1);
      end
      if (out_valid) begin
        if (model_q.size() == 0) begin
          check(1'b0, "stale_word", out_data, 0);
        end else if (out_ready) begin
          exp_w = model_q.pop_front();
          check(out_data == exp_w, "pop_data", out_data, exp_w);
        end else begin
          check(out_data == model_q[0], "head_data", out_data, model_q[0]);
        end
      end
      if (in_valid && in_ready) begin
        model_q.push_back(in_data);
        n_acc++;
      end
      if (rst || flush) begin
        model_q.delete();
      end
    end
  end

  task automatic drain(input string name);
    int c = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((model_q.size() != 0 || out_valid) && c < 300) begin
      tick();
      c++;
    end
    check(model_q.size() == 0 && !out_valid, name, model_q.size(), 0);
  endtask

  initial begin
    int base;
    int cyc;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
    check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    check(out_data == '0, "rst_out_data", out_data, 0);
    check(count == '0, "rst_count", count, 0);
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    // Single word: push in cycle 0, visible exactly in cycle LAT
    out_ready = 1'b1;
    for (int c = 0; c <= LAT + 2; c++) begin
      in_valid = (c == 0);
      in_data  = 32'hA5;
      @(negedge clk);
      if (c >= 1) begin
        check(out_valid == (c == LAT), "single_valid", out_valid, (c == LAT));
        check(int'(count) == ((c <= LAT) ? 1 : 0), "single_count", count, (c <= LAT) ? 1 : 0);
      end
      if (c == LAT) check(out_data == 32'hA5, "single_data", out_data, 32'hA5);
      tick();
    end
    in_valid = 1'b0;

    // Stream 0..99 with wrap: out_valid high for exactly 100 consecutive cycles
    out_ready = 1'b1;
    for (int c = 0; c < 100 + LAT + 6; c++) begin
      in_valid = (c < 100);
      in_data  = DW'(c);
      @(negedge clk);
      check(out_valid == (c >= LAT && c < LAT + 100), "stream_valid", out_valid,
            (c >= LAT && c < LAT + 100));
      tick();
    end
    in_valid = 1'b0;

    // Fill with consumer stalled: exactly CAP words accepted
    out_ready = 1'b0;
    base = n_acc;
    for (int c = 0; c < 26; c++) begin
      in_valid = 1'b1;
      in_data  = DW'(n_acc - base);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check(n_acc - base == CAP, "fill_accepted", n_acc - base, CAP);
    check(in_ready == 1'b0, "fill_in_ready", in_ready, 0);
    check(int'(count) == CAP, "fill_count", count, CAP);
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < CAP + 4; c++) begin
      @(negedge clk);
      check(out_valid == (c < CAP), "drain_valid", out_valid, (c < CAP));
      tick();
    end

    // Random backpressure over 1000 words
    base = n_acc;
    cyc  = 0;
    while (n_acc - base < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(1, 0) == 1);
      in_data   = $urandom;
      out_ready = ($urandom_range(9, 0) < 3);
      tick();
      cyc++;
    end
    check(n_acc - base == 1000, "random_progress", n_acc - base, 1000);
    drain("random_drain");

    // Reset mid-stream with 8 words queued
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h300 + DW'(i);
      tick();
    end
    rst     = 1'b1;
    in_data = 32'hDEAD;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check(out_valid == 1'b0, "mrst_out_valid", out_valid, 0);
    check(count == '0, "mrst_count", count, 0);
    check(in_ready == 1'b1, "mrst_in_ready", in_ready, 1);
    check(out_data == '0, "mrst_out_data", out_data, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h400 + DW'(i);
      tick();
    end
    drain("mrst_drain");

`ifdef IQUEUE_FLUSH_EN
    // Flush with reads in flight, popping in the flush cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h200 + DW'(i);
      tick();
    end
    flush     = 1'b1;
    in_data   = 32'h999;
    out_ready = 1'b1;
    @(negedge clk);
    check(in_ready == 1'b0, "flush_in_ready", in_ready, 0);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check(out_valid == 1'b0, "flush_out_valid", out_valid, 0);
    check(count == '0, "flush_count", count, 0);
    tick();
    in_valid = 1'b1;
    in_data  = 32'h11;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < LAT + 4 && !out_valid; c++) tick();
    @(negedge clk);
    check(out_valid && out_data == 32'h11, "flush_first_word", out_data, 32'h11);
    tick();
    drain("flush_drain");
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
